// File: rtl/q3c_pkg.sv
// Shared types for the q3c sequence controller: core/controller state encodings,
// default pattern width and the core next-state/output functions.
package q3c_pkg;

    localparam int unsigned DefaultW = 16;

    typedef enum logic [2:0] {
        CoreA = 3'd0,
        CoreB = 3'd1,
        CoreC = 3'd2,
        CoreD = 3'd3,
        CoreE = 3'd4
    } core_state_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } ctrl_state_e;

    // Unused codes 5-7 recover to A regardless of x.
    function automatic logic [2:0] core_next(input logic [2:0] s, input logic x);
        logic [2:0] n;
        n = CoreA;
        case (s)
            CoreA:   n = x ? CoreB : CoreA;
            CoreB:   n = x ? CoreE : CoreB;
            CoreC:   n = x ? CoreB : CoreC;
            CoreD:   n = x ? CoreC : CoreB;
            CoreE:   n = x ? CoreE : CoreD;
            default: n = CoreA;
        endcase
        return n;
    endfunction

    function automatic logic core_z(input logic [2:0] s);
        return (s == CoreD) || (s == CoreE);
    endfunction

endpackage

// File: rtl/q3c_fsm_core.sv
// Five-state core: clr forces A, en advances one step on x; z is high in D or E.
module q3c_fsm_core
    import q3c_pkg::*;
(
    input  logic       clk,
    input  logic       areset,
    input  logic       clr,
    input  logic       en,
    input  logic       x,
    output logic [2:0] y,
    output logic       z
);

    logic [2:0] state_q;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= CoreA;
        end else if (clr) begin
            state_q <= CoreA;
        end else if (en) begin
            state_q <= core_next(state_q, x);
        end
    end

    assign y = state_q;
    assign z = core_z(state_q);

endmodule

// File: rtl/q3c_seq_ctrl.sv
// Sequence controller: shifts a latched pattern LSB-first into q3c_fsm_core and
// counts steps landing in D/E. Define Q3C_SEQ_ABORT_EN to add the abort input.
module q3c_seq_ctrl
    import q3c_pkg::*;
#(
    parameter int unsigned W = DefaultW
) (
    input  logic               clk,
    input  logic               areset,
`ifdef Q3C_SEQ_ABORT_EN
    input  logic               abort,
`endif
    input  logic               start,
    input  logic [W-1:0]       pattern,
    input  logic [$clog2(W):0] len,
    output logic               busy,
    output logic               done,
    output logic               x,
    output logic [2:0]         y,
    output logic [$clog2(W):0] z_count,
    output logic               match
);

    localparam int unsigned LW = $clog2(W) + 1;

    ctrl_state_e   state_q;
    logic [W-1:0]  shift_q;
    logic [LW-1:0] cnt_q;
    logic [LW-1:0] zc_q;
    logic          match_q;
    logic [LW-1:0] len_clamped;
    logic          abort_w;
    logic          core_clr;
    logic          core_en;
    logic          core_z_w;

`ifdef Q3C_SEQ_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign len_clamped = (len > LW'(W)) ? LW'(W) : len;
    assign core_clr    = (state_q == StIdle) && start;
    assign core_en     = (state_q == StRun) && !abort_w;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            zc_q    <= '0;
            match_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        shift_q <= pattern;
                        cnt_q   <= len_clamped;
                        zc_q    <= '0;
                        state_q <= (len_clamped != '0) ? StRun : StDone;
                    end
                end
                StRun: begin
                    if (abort_w) begin
                        state_q <= StIdle;
                    end else begin
                        shift_q <= shift_q >> 1;
                        cnt_q   <= cnt_q - LW'(1);
                        // Count on the state the core is about to enter.
                        if (core_z(core_next(y, shift_q[0])) && (zc_q != LW'(W))) begin
                            zc_q <= zc_q + LW'(1);
                        end
                        if (cnt_q == LW'(1)) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    match_q <= core_z_w;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    q3c_fsm_core u_core (
        .clk    (clk),
        .areset (areset),
        .clr    (core_clr),
        .en     (core_en),
        .x      (x),
        .y      (y),
        .z      (core_z_w)
    );

    assign busy    = (state_q == StRun);
    assign done    = (state_q == StDone);
    assign x       = (state_q == StRun) ? shift_q[0] : 1'b0;
    assign z_count = zc_q;
    assign match   = match_q;

endmodule

// File: tb/tb_q3c_seq_ctrl.sv
// Directed self-checking bench for q3c_seq_ctrl (W=16); abort scenario runs only
// when Q3C_SEQ_ABORT_EN is defined.
module tb_q3c_seq_ctrl;

    logic        clk;
    logic        areset;
    logic        abort;
    logic        start;
    logic [15:0] pattern;
    logic [4:0]  len;
    logic        busy;
    logic        done;
    logic        x;
    logic [2:0]  y;
    logic [4:0]  z_count;
    logic        match;

    int passed;
    int total;

    q3c_seq_ctrl #(.W(16)) dut (
        .clk     (clk),
        .areset  (areset),
`ifdef Q3C_SEQ_ABORT_EN
        .abort   (abort),
`endif
        .start   (start),
        .pattern (pattern),
        .len     (len),
        .busy    (busy),
        .done    (done),
        .x       (x),
        .y       (y),
        .z_count (z_count),
        .match   (match)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents start for one edge; returns #1 after the accepting edge.
    task automatic launch(input logic [15:0] p, input logic [4:0] l);
        start   = 1'b1;
        pattern = p;
        len     = l;
        step();
        start   = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        step();
        step();
        total++;
        if ({busy, done, x, match} !== 4'b0000) begin
            $display("FAIL reset_flags: got %b expected 0000", {busy, done, x, match});
        end else passed++;
        total++;
        if ({y, z_count} !== 8'h00) begin
            $display("FAIL reset_state: y=%0d z_count=%0d expected 0/0", y, z_count);
        end else passed++;
        areset = 1'b0;
        step();
    endtask

    task automatic test_run_len4();
        logic [3:0] exp_x;
        logic [2:0] exp_y [4];
        exp_x = 4'b0011;
        exp_y = '{3'd1, 3'd4, 3'd3, 3'd1};
        launch(16'h0003, 5'd4);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (x !== exp_x[i] || busy !== 1'b1) begin
                $display("FAIL run4_x[%0d]: x=%b busy=%b expected x=%b busy=1", i, x, busy,
                         exp_x[i]);
            end else passed++;
            step();
            total++;
            if (y !== exp_y[i]) begin
                $display("FAIL run4_y[%0d]: got %0d expected %0d", i, y, exp_y[i]);
            end else passed++;
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || x !== 1'b0) begin
            $display("FAIL run4_done: done=%b busy=%b x=%b expected 1/0/0", done, busy, x);
        end else passed++;
        step();
        total++;
        if (done !== 1'b0 || z_count !== 5'd2 || match !== 1'b0) begin
            $display("FAIL run4_result: done=%b z_count=%0d match=%b expected 0/2/0", done,
                     z_count, match);
        end else passed++;
    endtask

    task automatic test_run_len3();
        launch(16'h0003, 5'd3);
        repeat (4) step();
        total++;
        if (y !== 3'd3 || z_count !== 5'd2 || match !== 1'b1) begin
            $display("FAIL run3_result: y=%0d z_count=%0d match=%b expected 3/2/1", y,
                     z_count, match);
        end else passed++;
        repeat (3) step();
        total++;
        if (y !== 3'd3 || z_count !== 5'd2 || match !== 1'b1) begin
            $display("FAIL run3_hold: y=%0d z_count=%0d match=%b expected 3/2/1", y,
                     z_count, match);
        end else passed++;
    endtask

    task automatic test_reset_midrun();
        launch(16'h0003, 5'd4);
        step();
        #1 areset = 1'b1;
        #1;
        total++;
        if ({busy, done, x, match} !== 4'b0000 || y !== 3'd0 || z_count !== 5'd0) begin
            $display("FAIL midrun_reset: busy=%b done=%b x=%b match=%b y=%0d z_count=%0d",
                     busy, done, x, match, y, z_count);
        end else passed++;
        #1 areset = 1'b0;
        step();
        launch(16'h0001, 5'd1);
        total++;
        if (busy !== 1'b1 || x !== 1'b1) begin
            $display("FAIL post_reset_run: busy=%b x=%b expected 1/1", busy, x);
        end else passed++;
        step();
        total++;
        if (done !== 1'b1 || y !== 3'd1 || z_count !== 5'd0) begin
            $display("FAIL post_reset_result: done=%b y=%0d z_count=%0d expected 1/1/0", done,
                     y, z_count);
        end else passed++;
        step();
    endtask

    task automatic test_len_zero();
        launch(16'hFFFF, 5'd0);
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || x !== 1'b0) begin
            $display("FAIL len0_done: done=%b busy=%b x=%b expected 1/0/0", done, busy, x);
        end else passed++;
        step();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || y !== 3'd0 || z_count !== 5'd0) begin
            $display("FAIL len0_result: done=%b busy=%b y=%0d z_count=%0d expected 0/0/0/0",
                     done, busy, y, z_count);
        end else passed++;
    endtask

    task automatic test_start_ignored();
        int dones;
        dones = 0;
        launch(16'h0003, 5'd4);
        for (int c = 0; c < 10; c++) begin
            if (done) dones++;
            if (c == 1) begin
                start   = 1'b1;
                pattern = 16'hFFFF;
                len     = 5'd7;
            end
            if (c == 2 || c == 5) start = 1'b0;
            if (c == 4) start = 1'b1;
            step();
        end
        total++;
        if (dones !== 1) begin
            $display("FAIL start_ignored_dones: got %0d expected 1", dones);
        end else passed++;
        total++;
        if (z_count !== 5'd2 || y !== 3'd1 || busy !== 1'b0) begin
            $display("FAIL start_ignored_result: z_count=%0d y=%0d busy=%b expected 2/1/0",
                     z_count, y, busy);
        end else passed++;
    endtask

    task automatic test_len_clamp();
        int busy_cycles;
        busy_cycles = 0;
        launch(16'hFFFF, 5'd31);
        for (int c = 0; c < 20; c++) begin
            if (busy) busy_cycles++;
            step();
        end
        total++;
        if (busy_cycles !== 16) begin
            $display("FAIL clamp_busy_cycles: got %0d expected 16", busy_cycles);
        end else passed++;
        total++;
        if (y !== 3'd4 || z_count !== 5'd15 || match !== 1'b1) begin
            $display("FAIL clamp_result: y=%0d z_count=%0d match=%b expected 4/15/1", y,
                     z_count, match);
        end else passed++;
    endtask

`ifdef Q3C_SEQ_ABORT_EN
    task automatic test_abort();
        int dones;
        dones = 0;
        launch(16'hFFFF, 5'd16);
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || z_count !== 5'd1 || y !== 3'd4) begin
            $display("FAIL abort_state: busy=%b done=%b z_count=%0d y=%0d expected 0/0/1/4",
                     busy, done, z_count, y);
        end else passed++;
        for (int c = 0; c < 5; c++) begin
            if (done) dones++;
            step();
        end
        total++;
        if (dones !== 0 || match !== 1'b1 || z_count !== 5'd1) begin
            $display("FAIL abort_after: dones=%0d match=%b z_count=%0d expected 0/1/1", dones,
                     match, z_count);
        end else passed++;
    endtask
`endif

    initial begin
        passed  = 0;
        total   = 0;
        areset  = 1'b0;
        abort   = 1'b0;
        start   = 1'b0;
        pattern = '0;
        len     = '0;
        #2;
        test_reset();
        test_run_len4();
        test_run_len3();
        test_reset_midrun();
        test_len_zero();
        test_start_ignored();
        test_len_clamp();
`ifdef Q3C_SEQ_ABORT_EN
        test_abort();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
